// File: rtl/serv_dbg_rf_trace.sv
// Register-write trace capture for the SERV RF RAM write port.
// Rebuilds RF_WIDTH-bit beats into 32-bit register writes and queues them for the debug module.
module serv_dbg_rf_trace #(
   parameter int RF_WIDTH = 8,
   parameter int RF_L2D   = $clog2((32+4)*32/RF_WIDTH),
   parameter int DEPTH    = 8
) (
   input  logic                     clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic                     i_clr,
   input  logic [RF_L2D-1:0]        i_waddr,
   input  logic [RF_WIDTH-1:0]      i_wdata,
   input  logic                     i_wen,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [5:0]               o_reg,
   output logic [31:0]              o_data,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_overflow,
   output logic                     o_err
);

   localparam int LANES = 32/RF_WIDTH;
   localparam int LB    = $clog2(LANES);
   localparam int AW    = $clog2(DEPTH);

   // Two assembly slots: rd and CSR write-backs may interleave beat by beat.
   logic [1:0]           r_busy;
   logic [1:0][5:0]      r_sreg;
   logic [1:0][LB-1:0]   r_next;
   logic [1:0][31:0]     r_word;

   logic [37:0]          r_mem [DEPTH];
   logic [AW-1:0]        r_rd;
   logic [AW-1:0]        r_wr;
   logic [AW:0]          r_cnt;
   logic                 r_ovf;
   logic                 r_err;

   logic [5:0]           w_reg;
   logic [LB-1:0]        w_lane;
   logic [1:0]           w_match;
   logic [1:0]           w_seq;
   logic                 w_hit;
   logic                 w_sel;
   logic                 w_bad;
   logic                 w_last;
   logic [31:0]          w_word;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_wr;

   assign w_reg  = i_waddr[RF_L2D-1:LB];
   assign w_lane = i_waddr[LB-1:0];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_match[i] = r_busy[i] && (r_sreg[i] == w_reg);
         w_seq[i]   = w_match[i] && (r_next[i] == w_lane);
      end
   end

   // Slot selection: lane 0 restarts a matching slot or takes the lowest free one;
   // later lanes must land on the slot expecting exactly that lane.
   always_comb begin
      w_hit = 1'b0;
      w_sel = 1'b0;
      w_bad = 1'b0;
      if (i_wen && (w_lane == '0) && i_en) begin
         if (w_match[0]) begin
            w_hit = 1'b1;
         end else if (w_match[1]) begin
            w_hit = 1'b1;
            w_sel = 1'b1;
         end else if (!r_busy[0]) begin
            w_hit = 1'b1;
         end else if (!r_busy[1]) begin
            w_hit = 1'b1;
            w_sel = 1'b1;
         end else begin
            w_bad = 1'b1;
         end
      end else if (i_wen && (w_lane != '0)) begin
         if (w_seq[0]) begin
            w_hit = 1'b1;
         end else if (w_seq[1]) begin
            w_hit = 1'b1;
            w_sel = 1'b1;
         end else begin
            w_bad = 1'b1;
         end
      end
   end

   always_comb begin
      w_word = (w_lane == '0) ? 32'd0 : r_word[w_sel];
      w_word[w_lane*RF_WIDTH +: RF_WIDTH] = i_wdata;
   end

   assign w_last  = w_hit && (w_lane == LB'(LANES-1));
   assign w_full  = (r_cnt == (AW+1)'(DEPTH));
   assign w_pop   = o_valid && i_ready;
   assign w_wr    = w_last && (!w_full || w_pop);

   assign o_valid    = (r_cnt != '0);
   assign o_reg      = o_valid ? r_mem[r_rd][37:32] : 6'd0;
   assign o_data     = o_valid ? r_mem[r_rd][31:0]  : 32'd0;
   assign o_level    = r_cnt;
   assign o_overflow = r_ovf;
   assign o_err      = r_err;

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy <= '0;
         r_next <= '0;
         r_rd   <= '0;
         r_wr   <= '0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
         r_err  <= 1'b0;
      end else if (i_clr) begin
         r_busy <= '0;
         r_next <= '0;
         r_rd   <= '0;
         r_wr   <= '0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         if (w_bad)
            r_err <= 1'b1;
         if (w_hit) begin
            if (w_lane == '0) begin
               r_busy[w_sel] <= 1'b1;
               r_next[w_sel] <= LB'(1);
            end else if (w_last) begin
               r_busy[w_sel] <= 1'b0;
            end else begin
               r_next[w_sel] <= r_next[w_sel] + 1'b1;
            end
         end
         if (w_last && w_full && !w_pop)
            r_ovf <= 1'b1;
         if (w_wr)
            r_wr <= r_wr + 1'b1;
         if (w_pop)
            r_rd <= r_rd + 1'b1;
         if (w_wr && !w_pop)
            r_cnt <= r_cnt + 1'b1;
         else if (!w_wr && w_pop)
            r_cnt <= r_cnt - 1'b1;
      end
   end

   // Datapath storage carries no reset; occupancy and busy flags qualify it.
   always_ff @(posedge clk) begin
      if (w_hit) begin
         r_sreg[w_sel] <= w_reg;
         r_word[w_sel] <= w_word;
      end
      if (w_wr && !i_clr)
         r_mem[r_wr] <= {w_reg, w_word};
   end

endmodule
